// File: rtl/booth_mult_control_pkg.sv
// Shared constants for the radix-4 Booth multiplier sequencer: FSM encodings,
// Booth window codes, the decoded control struct and the iteration-count helper.
package booth_mult_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Booth windows {m[i+1], m[i], m[i-1]}
    localparam logic [2:0] BW_ZERO_P = 3'b000;
    localparam logic [2:0] BW_P1_A   = 3'b001;
    localparam logic [2:0] BW_P1_B   = 3'b010;
    localparam logic [2:0] BW_P2     = 3'b011;
    localparam logic [2:0] BW_M2     = 3'b100;
    localparam logic [2:0] BW_M1_A   = 3'b101;
    localparam logic [2:0] BW_M1_B   = 3'b110;
    localparam logic [2:0] BW_ZERO_N = 3'b111;

    typedef struct packed {
        logic add;
        logic sub;
        logic x2;
    } booth_ctrl_t;

    // Unsigned operands need one extra zero-extended window.
    function automatic int iters(input int width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_mult_control_if.sv
// Handshake and datapath-control bundle between the Booth sequencer (master)
// and the shift-add datapath / requester (slave).
interface booth_mult_control_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             is_signed;
    logic [2:0]       booth_bits;
    logic             load;
    logic             add;
    logic             sub;
    logic             shift_multiplicand;
    logic             shift_product;
    logic             ready;
    logic             done;
    logic [CNT_W-1:0] iter;

    modport master (
        input  start, is_signed, booth_bits,
        output load, add, sub, shift_multiplicand, shift_product, ready, done, iter
    );

    modport slave (
        output start, is_signed, booth_bits,
        input  load, add, sub, shift_multiplicand, shift_product, ready, done, iter
    );
endinterface

// File: rtl/booth_window_decode.sv
// Combinational radix-4 Booth recoding of one 3-bit multiplier window into
// add / sub / select-2M controls.
module booth_window_decode
    import booth_mult_pkg::*;
(
    input  logic [2:0]  window,
    output booth_ctrl_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (window)
            BW_ZERO_P, BW_ZERO_N: ctrl = '0;
            BW_P1_A, BW_P1_B: ctrl.add = 1'b1;
            BW_P2: begin
                ctrl.add = 1'b1;
                ctrl.x2  = 1'b1;
            end
            BW_M2: begin
                ctrl.sub = 1'b1;
                ctrl.x2  = 1'b1;
            end
            BW_M1_A, BW_M1_B: ctrl.sub = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_control.sv
// Radix-4 Booth multiplier sequencer driving an external shift-add datapath.
// Optional SKIP_ZERO_EN: trivial windows shift in EVAL and bypass SHIFT.
module booth_mult_control
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
    input logic                  clock,
    input logic                  reset_n,
    booth_mult_control_if.master bus
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] iters_target;
    logic             mode_signed_q;
    logic             last_iter;
    logic             in_eval;
    booth_ctrl_t      win_ctrl;

    booth_window_decode u_decode (
        .window (bus.booth_bits),
        .ctrl   (win_ctrl)
    );

    assign iters_target = CNT_W'(iters(WIDTH, mode_signed_q));
    assign last_iter    = (iter_q + CNT_W'(1)) == iters_target;
    assign in_eval      = (state_q == ST_EVAL);

`ifdef SKIP_ZERO_EN
    logic trivial;
    assign trivial = ~(win_ctrl.add | win_ctrl.sub);
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD: begin
                iter_d  = '0;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
`ifdef SKIP_ZERO_EN
                if (trivial) begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = last_iter ? ST_DONE : ST_EVAL;
                end else begin
                    state_d = ST_SHIFT;
                end
`else
                state_d = ST_SHIFT;
`endif
            end
            ST_SHIFT: begin
                iter_d  = iter_q + CNT_W'(1);
                state_d = last_iter ? ST_DONE : ST_EVAL;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            iter_q        <= '0;
            mode_signed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            if (state_q == ST_IDLE && bus.start) mode_signed_q <= bus.is_signed;
        end
    end

    // Controls are state decodes; only EVAL looks at the live window.
    assign bus.ready              = (state_q == ST_IDLE);
    assign bus.load               = (state_q == ST_LOAD);
    assign bus.done               = (state_q == ST_DONE);
    assign bus.add                = in_eval & win_ctrl.add;
    assign bus.sub                = in_eval & win_ctrl.sub;
    assign bus.shift_multiplicand = in_eval & win_ctrl.x2;
    assign bus.iter               = iter_q;
`ifdef SKIP_ZERO_EN
    assign bus.shift_product = (state_q == ST_SHIFT) | (in_eval & trivial);
`else
    assign bus.shift_product = (state_q == ST_SHIFT);
`endif

endmodule

// File: tb/tb_booth_mult_control.sv
// Directed bench for booth_mult_control at WIDTH=8: decode table, latency,
// iteration count, mid-operation reset and start handshake corner cases.
module tb_booth_mult_control;

    localparam int W  = 8;
    localparam int CW = $clog2(W / 2 + 2);
`ifdef SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    booth_mult_control_if #(.CNT_W(CW)) bus ();

    booth_mult_control #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] win;
        int         add;
        int         sub;
        int         x2;
    } dec_vec_t;

    dec_vec_t   tbl [8];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] wins [6];
    int         obs_add [6];
    int         obs_sub [6];
    int         obs_x2 [6];
    int         adds, subs, shifts;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int n_iters(input logic sgn);
        return sgn ? (W / 2) : (W / 2 + 1);
    endfunction

    function automatic int exp_latency(input logic sgn);
        int it;
        int triv;
        it   = n_iters(sgn);
        triv = 0;
        for (int j = 0; j < it; j++)
            if (wins[j] == 3'b000 || wins[j] == 3'b111) triv++;
        return 2 + 2 * it - (SKIP ? triv : 0);
    endfunction

    // Latency n counts rising edges with the start-accept edge as edge 1.
    task automatic run_op(input string tag, input logic sgn, input bit pulse_mid);
        int n, k, loads, excl;
        bit got, pulsed, quiet;
        adds = 0; subs = 0; shifts = 0; loads = 0; excl = 0;
        for (int j = 0; j < 6; j++) begin
            obs_add[j] = 0; obs_sub[j] = 0; obs_x2[j] = 0;
        end
        @(negedge clock);
        check($sformatf("%s ready_before", tag), int'(bus.ready), 1);
        bus.start      = 1'b1;
        bus.is_signed  = sgn;
        bus.booth_bits = wins[0];
        @(posedge clock);
        n = 1; k = 0; got = 0; pulsed = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            bus.start     = 1'b0;
            bus.is_signed = ~sgn;
            if (bus.load) loads++;
            if (bus.add && bus.sub) excl++;
            if (bus.shift_multiplicand && !(bus.add || bus.sub)) excl++;
            if ((bus.add || bus.sub) && (bus.load || bus.shift_product)) excl++;
            if (bus.add) adds++;
            if (bus.sub) subs++;
            if (!bus.load && !bus.done && !bus.ready && !bus.shift_product) begin
                if (k < 6) begin
                    obs_add[k] = int'(bus.add);
                    obs_sub[k] = int'(bus.sub);
                    obs_x2[k]  = int'(bus.shift_multiplicand);
                end
                if (pulse_mid && !pulsed) begin
                    bus.start = 1'b1;
                    pulsed    = 1'b1;
                end
            end
            if (bus.shift_product) begin
                shifts++;
                k++;
                bus.booth_bits = wins[(k < 6) ? k : 5];
            end
            if (bus.done) begin
                got = 1'b1;
                check($sformatf("%s latency", tag), n, exp_latency(sgn));
                check($sformatf("%s iter_at_done", tag), int'(bus.iter), n_iters(sgn));
                check($sformatf("%s ready_at_done", tag), int'(bus.ready), 0);
            end else begin
                @(posedge clock);
                n++;
            end
        end
        bus.start = 1'b0;
        if (!got) check($sformatf("%s done_timeout", tag), 0, 1);
        check($sformatf("%s shift_pulses", tag), shifts, n_iters(sgn));
        check($sformatf("%s load_pulses", tag), loads, 1);
        check($sformatf("%s exclusivity", tag), excl, 0);
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c == 0) check($sformatf("%s ready_after", tag), int'(bus.ready), 1);
            if (bus.done || bus.load) quiet = 1'b0;
        end
        check($sformatf("%s quiet_after", tag), int'(quiet), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp, dn;
        bit d;
        tbl[0] = '{3'b000, 0, 0, 0};
        tbl[1] = '{3'b001, 1, 0, 0};
        tbl[2] = '{3'b010, 1, 0, 0};
        tbl[3] = '{3'b011, 1, 0, 1};
        tbl[4] = '{3'b100, 0, 1, 1};
        tbl[5] = '{3'b101, 0, 1, 0};
        tbl[6] = '{3'b110, 0, 1, 0};
        tbl[7] = '{3'b111, 0, 0, 0};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.booth_bits = 3'b000;
        repeat (3) @(negedge clock);
        check("reset ready", int'(bus.ready), 1);
        check("reset load", int'(bus.load), 0);
        check("reset add", int'(bus.add), 0);
        check("reset sub", int'(bus.sub), 0);
        check("reset x2", int'(bus.shift_multiplicand), 0);
        check("reset shift_product", int'(bus.shift_product), 0);
        check("reset done", int'(bus.done), 0);
        check("reset iter", int'(bus.iter), 0);
        reset_n = 1'b1;

        for (int b = 0; b < 8; b += 4) begin
            for (int j = 0; j < 6; j++) wins[j] = (j < 4) ? tbl[b + j].win : 3'b000;
            run_op($sformatf("table%0d", b / 4), 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) begin
                check($sformatf("dec %b add", tbl[b + j].win), obs_add[j], tbl[b + j].add);
                check($sformatf("dec %b sub", tbl[b + j].win), obs_sub[j], tbl[b + j].sub);
                check($sformatf("dec %b x2", tbl[b + j].win), obs_x2[j], tbl[b + j].x2);
            end
        end

        for (int j = 0; j < 6; j++) wins[j] = 3'b001;
        run_op("unsigned5", 1'b0, 1'b0);
        check("unsigned5 adds", adds, 5);
        check("unsigned5 subs", subs, 0);

        wins[0] = 3'b000; wins[1] = 3'b111; wins[2] = 3'b000; wins[3] = 3'b111;
        run_op("trivial", 1'b1, 1'b0);
        check("trivial add_sub", adds + subs, 0);

        for (int j = 0; j < 6; j++) wins[j] = 3'b000;
        run_op("allzero", 1'b1, 1'b0);

        for (int j = 0; j < 6; j++) wins[j] = 3'b110;
        run_op("midstart", 1'b1, 1'b1);
        check("midstart subs", subs, 4);

        // Asynchronous reset in the second SHIFT.
        for (int j = 0; j < 6; j++) wins[j] = 3'b001;
        @(negedge clock);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.booth_bits = 3'b001;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        sp = 0;
        for (int c = 0; c < 40 && sp < 2; c++) begin
            if (c > 0) @(negedge clock);
            if (bus.shift_product) sp++;
        end
        check("abort reached_shift2", sp, 2);
        #2 reset_n = 1'b0;
        #1;
        check("abort ready", int'(bus.ready), 1);
        check("abort shift_product", int'(bus.shift_product), 0);
        check("abort load", int'(bus.load), 0);
        check("abort add", int'(bus.add), 0);
        check("abort done", int'(bus.done), 0);
        check("abort iter", int'(bus.iter), 0);
        @(negedge clock);
        reset_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.done) dn++;
        end
        check("abort no_done", dn, 0);
        run_op("after_abort", 1'b1, 1'b0);

        // start held high through DONE relaunches from IDLE.
        @(negedge clock);
        bus.start = 1'b1; bus.is_signed = 1'b1;
        d = 1'b0;
        for (int c = 0; c < 40 && !d; c++) begin
            @(negedge clock);
            if (bus.done) d = 1'b1;
        end
        check("held done_seen", int'(d), 1);
        @(negedge clock);
        check("held ready_after_done", int'(bus.ready), 1);
        @(negedge clock);
        check("held relaunch_load", int'(bus.load), 1);
        bus.start = 1'b0;
        d = 1'b0;
        for (int c = 0; c < 40 && !d; c++) begin
            @(negedge clock);
            if (bus.done) d = 1'b1;
        end
        check("held second_done", int'(d), 1);
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_control.md
Name: booth_mult_control

Overview:
- Parametrised radix-4 Booth multiplier sequencer; successor to the fixed-width multiplier control.
- Drives an external shift-add datapath: requests operand load, decodes each 3-bit Booth window into add/sub/×2 controls, sequences product shifts and signals completion.
- Adds operand-width generalisation, a signed/unsigned mode, a start/ready handshake, a done pulse and an iteration count.

Parameters:
- WIDTH, 32, operand width in bits; even, ≥4.
- CNT_W, $clog2(WIDTH/2+2), iteration counter width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- is_signed  in  1  operand mode, sampled with an accepted start
- booth_bits  in  3  current multiplier window {m[i+1], m[i], m[i-1]} from datapath
- load  out  1  datapath loads operands and clears product
- add  out  1  product += selected multiplicand
- sub  out  1  product −= selected multiplicand
- shift_multiplicand  out  1  select 2×M instead of M (valid with add or sub only)
- shift_product  out  1  arithmetic shift product/multiplier right by 2
- ready  out  1  idle and able to accept start
- done  out  1  one-cycle pulse: result valid
- iter  out  CNT_W  completed iterations

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, ready=1, all other outputs 0, iter=0. Reset mid-operation aborts; no done is produced.
- ITERS = WIDTH/2 when signed, WIDTH/2+1 when unsigned (extra zero-extended window). Mode is latched at start.
- States:
  - IDLE: ready=1. start=1 → LOAD; otherwise stay.
  - LOAD: load=1 for one cycle; iter←0 → EVAL.
  - EVAL: decode booth_bits:
    - 000/111: no add, no sub
    - 001/010: add
    - 011: add + shift_multiplicand
    - 100: sub + shift_multiplicand
    - 101/110: sub
    - Next → SHIFT.
  - SHIFT: shift_product=1; iter←iter+1. If iter+1==ITERS → DONE; else → EVAL.
  - DONE: done=1 for one cycle, ready=0 → IDLE. ready rises the following cycle.
- Latency from start-accept edge to done: 1 + 2·ITERS + 1 cycles. WIDTH=32 gives 34 cycles signed, 36 unsigned.
- start when ready=0 is ignored, with no queuing. start held high through DONE launches a new operation from IDLE.
- add and sub are never both 1. shift_multiplicand=1 only with add or sub. load, EVAL controls and shift_product are mutually exclusive by state.
- All outputs are registered-state decodes: Moore, glitch-free relative to state. booth_bits is sampled combinationally in EVAL only.

Optional Feature:
- Macro SKIP_ZERO_EN.
- Defined: in EVAL, a trivial window (000/111) asserts shift_product in the same cycle, increments iter, and bypasses SHIFT (→ EVAL or DONE). Latency becomes variable: 2 + 2·ITERS − (number of trivial windows).
- Undefined: fixed latency as above; booth_bits has no effect on timing.

Decomposition:
- Package booth_mult_pkg:
  - state enum (IDLE, LOAD, EVAL, SHIFT, DONE)
  - Booth window constants
  - function iters(width, signed)
- Sub-module booth_window_decode: combinational 3-bit → {add, sub, x2}, instantiated once.

Test Plan:
- WIDTH=8, signed, windows 010,011,100,110 → EVAL outputs add; add+x2; sub+x2; sub. done pulse exactly 10 cycles after start-accept; iter=4 at done.
- WIDTH=8, unsigned, five windows 001 → five add pulses, five shift_product pulses; done at cycle 12.
- Windows 000 then 111 → no add or sub in EVAL; shift_product still asserted each SHIFT.
- reset_n driven low in the 2nd SHIFT → same-edge-independent: ready=1, all other outputs 0, iter=0. No done after release. A new start then completes normally.
- start pulsed during EVAL → ignored; done count stays 1; timing unchanged.
- SKIP_ZERO_EN, WIDTH=8, signed, all windows 000 → no SHIFT state; done 6 cycles after start-accept.
